i2c_slave_responder: RTL and testbench
======================================

# i2c_slave_responder

- Synthesizable I2C slave/responder for the far end of the iicmb controller's SCL/SDA bus.
- Detects START/STOP, matches a 7-bit address and ACKs it.
- Write bytes go into a small register file through an auto-incrementing pointer; read data is returned from that file.
- Used as the responding device on the I2C side of the controller in block-level and system benches.

## Interface
Parameters:
- SLAVE_ADDR, 7'h22, 7-bit device address (address byte 0x44 = write, 0x45 = read)
- MEM_AW, 4, register-file address width; depth 2**MEM_AW bytes

Ports:
- clk_i  in  1  system clock; all logic on rising edge
- rst_ni  in  1  reset, asynchronous assert, active-low
- scl_i  in  1  I2C clock from the bus; raw and asynchronous
- sda_i  in  1  I2C data from the bus; raw and asynchronous
- sda_o  out  1  open-drain data drive; 0 = pull low, 1 = release
- rx_valid_o  out  1  one-cycle strobe: a data byte was stored
- rx_data_o  out  8  byte stored; held until the next strobe
- rx_addr_o  out  MEM_AW  register address the byte was stored to
- busy_o  out  1  high from an addressed START until STOP

## Operation
Input conditioning:
- scl_i and sda_i pass through 2-FF synchronizers plus one history flop.
- START = sda falling while scl high. STOP = sda rising while scl high.
- scl rise/fall are edges of the synchronized scl.

FSM states:
- IDLE: wait for START.
- ADDR: shift 8 bits MSB-first on scl rises.
  - On match, go to ACK_ADDR.
  - On mismatch, go to IGNORE with sda released (NAK).
- ACK_ADDR: drive ACK. Bit0 = 0 goes to RX_BYTE; bit0 = 1 loads the tx shift register from mem[ptr] and goes to TX_BYTE.
- RX_BYTE: shift 8 bits, then ACK_RX.
  - First data byte after a write address loads ptr (low MEM_AW bits) and is not stored.
  - Later bytes are written to mem[ptr], pulse rx_valid_o, then ptr++.
- ACK_RX: drive ACK, then return to RX_BYTE.
- TX_BYTE: present 8 bits MSB-first, then MACK.
- MACK: sample the master's bit on scl rise.
  - 0 = ACK: ptr++, reload from mem[ptr], go to TX_BYTE.
  - 1 = NAK: go to IGNORE.
- IGNORE: sda released; wait for START or STOP.

Global rules:
- START in any state (including a repeated START) goes to ADDR with the bit counter cleared. ptr is retained.
- STOP in any state goes to IDLE.
- START/STOP detection takes priority over an scl edge in the same cycle.
- 3-bit bit counter, cleared on START and at each byte boundary.
- ptr wraps modulo 2**MEM_AW (0xF + 1 = 0x0 with MEM_AW = 4).
- The register file is never written in TX or IGNORE.

## Timing
Reset values:
- sda_o = 1; rx_valid_o = 0; rx_data_o = 0; rx_addr_o = 0; busy_o = 0.
- ptr = 0; all memory bytes = 0x00; state = IDLE.
- Assertion of rst_ni releases sda immediately, including mid-transfer.

Latency and drive rules:
- Pin-to-event latency is 3 clk_i cycles.
- sda_o changes only on the detected scl fall, never while scl is high, so it cannot create a false START/STOP.
- ACK: sda_o goes low on the scl fall after the 8th rise; released on the next scl fall.
- TX bit n: driven on the scl fall preceding its rise. After bit 0's fall, sda is released for MACK.
- Data is sampled on detected scl rise.
- rx_valid_o pulses 1 cycle, on the scl rise of the 8th bit of a stored byte. rx_data_o and rx_addr_o update in the same cycle.

Requirements on the bus clock:
- clk_i period ≤ 1/16 of the scl period.
- scl high and low phases are each ≥ 6 clk_i cycles.
- No clock stretching; scl is never driven.

## Structure
- Package i2c_resp_pkg holds:
  - state enum i2c_resp_state_t (IDLE, ADDR, ACK_ADDR, RX_BYTE, ACK_RX, TX_BYTE, MACK, IGNORE)
  - constants I2C_ACK = 1'b0, I2C_NAK = 1'b1
  - constant I2C_RW_READ = 1'b1
- Sub-module i2c_bus_sync: synchronizers, scl rise/fall strobes, start/stop strobes. All are one-cycle pulses.
- Top module holds the FSM, shift registers, ptr and the register file.

## Test plan
- Write: START, 0x44, 0x05, 0x78, STOP.
  - ACK on all three bytes.
  - One rx_valid_o pulse with rx_data_o = 0x78, rx_addr_o = 5; mem[5] = 0x78.
  - busy_o drops after STOP.
- Read with repeated START: START 0x44, 0x05, rSTART 0x45, read 1 byte, master NAK, STOP.
  - Returns 0x78.
  - sda released during MACK.
  - No rx_valid_o pulse.
- Address mismatch: START 0x46, 0xAA, STOP.
  - sda_o stays 1 for the whole transfer; no pulse; memory unchanged.
- Wrap: START 0x44, 0x0F, 0x11, 0x22, STOP.
  - mem[0xF] = 0x11, mem[0x0] = 0x22.
  - rx_addr_o sequence is F then 0.
- Burst read: START 0x44, 0x0F, rSTART 0x45; master ACKs the first byte, NAKs the second.
  - Returns 0x11 then 0x22.
- Reset mid-read: drop rst_ni while sda_o = 0 during TX.
  - sda_o = 1 in the same cycle; busy_o = 0.
  - After release: state IDLE, memory cleared; the next address byte is ACKed normally.

Source files
------------

// File: rtl/i2c_resp_pkg.sv
// Shared types and constants for the I2C slave responder.
//   i2c_resp_state_t : responder FSM states
//   I2C_ACK / I2C_NAK: bus level of the acknowledge bit
//   I2C_RW_READ      : value of the R/W bit that selects a read transfer
package i2c_resp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_ADDR,
    RX_BYTE,
    ACK_RX,
    TX_BYTE,
    MACK,
    IGNORE
  } i2c_resp_state_t;

  localparam logic I2C_ACK     = 1'b0;
  localparam logic I2C_NAK     = 1'b1;
  localparam logic I2C_RW_READ = 1'b1;

endpackage

// File: rtl/i2c_resp_bus_sync.sv
// Input conditioning for the raw I2C pins.
// Each pin goes through a 2-FF synchronizer plus one history flop. All strobe
// outputs are single-cycle pulses derived from the synchronized/history pair.
// Ports:
//   clk_i, rst_ni     : system clock, asynchronous active-low reset
//   scl_i, sda_i      : raw asynchronous bus pins
//   sda_sync_o        : synchronized SDA level (for data sampling)
//   scl_rise_o/fall_o : edges of the synchronized SCL
//   start_o / stop_o  : SDA falling / rising while SCL is high
module i2c_bus_sync
  import i2c_resp_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_sync_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic scl_meta_q, scl_sync_q, scl_hist_q;
  logic sda_meta_q, sda_sync_q, sda_hist_q;

  // Idle bus is high, so reset all stages to 1 to avoid a spurious edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_hist_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_i;
      scl_sync_q <= scl_meta_q;
      scl_hist_q <= scl_sync_q;
      sda_meta_q <= sda_i;
      sda_sync_q <= sda_meta_q;
      sda_hist_q <= sda_sync_q;
    end
  end

  assign sda_sync_o = sda_sync_q;
  assign scl_rise_o = scl_sync_q & ~scl_hist_q;
  assign scl_fall_o = ~scl_sync_q & scl_hist_q;
  // SCL must be high in both samples so an SDA edge racing an SCL edge
  // is not mistaken for a bus condition.
  assign start_o    = scl_sync_q & scl_hist_q & sda_hist_q & ~sda_sync_q;
  assign stop_o     = scl_sync_q & scl_hist_q & ~sda_hist_q & sda_sync_q;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C slave responder: detects START/STOP, matches a 7-bit address, stores
// written bytes into a small register file via an auto-incrementing pointer
// and returns bytes from that file on reads.
// Ports:
//   clk_i, rst_ni   : system clock, asynchronous active-low reset
//   scl_i, sda_i    : raw I2C bus pins
//   sda_o           : open-drain SDA drive (0 = pull low, 1 = release)
//   rx_valid_o      : one-cycle strobe when a data byte is stored
//   rx_data_o       : last stored byte
//   rx_addr_o       : register address of the last stored byte
//   busy_o          : high from an addressed START until STOP
module i2c_slave_responder
  import i2c_resp_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h22,
  parameter int         MEM_AW     = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_o,
  output logic              rx_valid_o,
  output logic [7:0]        rx_data_o,
  output logic [MEM_AW-1:0] rx_addr_o,
  output logic              busy_o
);

  localparam int DEPTH = 1 << MEM_AW;

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync u_sync (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_sync_o (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  i2c_resp_state_t   state_q, state_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [6:0]        shift_q, shift_d;   // 7 bits kept; 8th comes straight from sda_s
  logic [7:0]        tx_q, tx_d;
  logic [MEM_AW-1:0] ptr_q, ptr_d;
  logic              first_q, first_d;   // next received byte is the pointer
  logic              mack_ok_q, mack_ok_d; // master ACKed; drive next byte on fall
  logic              sda_q, sda_d;
  logic              busy_q, busy_d;
  logic              rx_valid_q, rx_valid_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic [MEM_AW-1:0] rx_addr_q, rx_addr_d;
  logic [7:0]        mem_q [DEPTH];

  logic              wr_en;
  logic [7:0]        byte_w;
  logic [MEM_AW-1:0] ptr_inc;
  logic              last_bit;

  assign byte_w   = {shift_q, sda_s};
  assign ptr_inc  = ptr_q + MEM_AW'(1);
  assign last_bit = (bitcnt_q == 3'd7);

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    ptr_d      = ptr_q;
    first_d    = first_q;
    mack_ok_d  = mack_ok_q;
    sda_d      = sda_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    rx_addr_d  = rx_addr_q;
    wr_en      = 1'b0;

    // Bus conditions win over any scl edge seen in the same cycle.
    if (start_det) begin
      state_d   = ADDR;
      bitcnt_d  = 3'd0;
      mack_ok_d = 1'b0;
      sda_d     = 1'b1;
    end else if (stop_det) begin
      state_d   = IDLE;
      bitcnt_d  = 3'd0;
      mack_ok_d = 1'b0;
      sda_d     = 1'b1;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;

        ADDR: begin
          if (scl_rise) begin
            shift_d  = byte_w[6:0];
            bitcnt_d = bitcnt_q + 3'd1;
            if (last_bit) begin
              if (byte_w[7:1] == SLAVE_ADDR) begin
                state_d = ACK_ADDR;
                busy_d  = 1'b1;
              end else begin
                state_d = IGNORE;
              end
            end
          end
        end

        // sda_q doubles as the phase flag: released = ACK not yet driven.
        // shift_q[0] still holds the R/W bit here.
        ACK_ADDR: begin
          if (scl_fall) begin
            if (sda_q == I2C_NAK) begin
              sda_d = I2C_ACK;
            end else if (shift_q[0] == I2C_RW_READ) begin
              tx_d     = mem_q[ptr_q];
              sda_d    = mem_q[ptr_q][7];
              bitcnt_d = 3'd0;
              state_d  = TX_BYTE;
            end else begin
              sda_d    = 1'b1;
              first_d  = 1'b1;
              bitcnt_d = 3'd0;
              state_d  = RX_BYTE;
            end
          end
        end

        RX_BYTE: begin
          if (scl_rise) begin
            shift_d  = byte_w[6:0];
            bitcnt_d = bitcnt_q + 3'd1;
            if (last_bit) begin
              state_d = ACK_RX;
              if (first_q) begin
                ptr_d   = byte_w[MEM_AW-1:0];
                first_d = 1'b0;
              end else begin
                wr_en      = 1'b1;
                rx_valid_d = 1'b1;
                rx_data_d  = byte_w;
                rx_addr_d  = ptr_q;
                ptr_d      = ptr_inc;
              end
            end
          end
        end

        ACK_RX: begin
          if (scl_fall) begin
            if (sda_q == I2C_NAK) begin
              sda_d = I2C_ACK;
            end else begin
              sda_d    = 1'b1;
              bitcnt_d = 3'd0;
              state_d  = RX_BYTE;
            end
          end
        end

        // Entered on a fall with bit 7 already driven; a fall with the
        // counter wrapped back to 0 means all 8 bits have been clocked.
        TX_BYTE: begin
          if (scl_rise) begin
            bitcnt_d = bitcnt_q + 3'd1;
          end else if (scl_fall) begin
            if (bitcnt_q == 3'd0) begin
              sda_d   = 1'b1;
              state_d = MACK;
            end else begin
              tx_d  = {tx_q[6:0], 1'b0};
              sda_d = tx_q[6];
            end
          end
        end

        MACK: begin
          if (scl_rise) begin
            if (sda_s == I2C_ACK) begin
              ptr_d     = ptr_inc;
              tx_d      = mem_q[ptr_inc];
              mack_ok_d = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end else if (scl_fall && mack_ok_q) begin
            mack_ok_d = 1'b0;
            sda_d     = tx_q[7];
            bitcnt_d  = 3'd0;
            state_d   = TX_BYTE;
          end
        end

        IGNORE: sda_d = 1'b1;

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      bitcnt_q   <= 3'd0;
      shift_q    <= '0;
      tx_q       <= '0;
      ptr_q      <= '0;
      first_q    <= 1'b0;
      mack_ok_q  <= 1'b0;
      sda_q      <= 1'b1;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ptr_q      <= ptr_d;
      first_q    <= first_d;
      mack_ok_q  <= mack_ok_d;
      sda_q      <= sda_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_addr_q  <= rx_addr_d;
    end
  end

  // Register file is cleared by reset so a bench always starts from zeros.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[ptr_q] <= byte_w;
    end
  end

  assign sda_o      = sda_q;
  assign rx_valid_o = rx_valid_q;
  assign rx_data_o  = rx_data_q;
  assign rx_addr_o  = rx_addr_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench for i2c_slave_responder: a bit-banged I2C master drives the
// bus (wired-AND with the responder's sda_o) and checks ACKs, read data and
// the rx strobe against hand-computed values.
module tb_i2c_slave_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl;
  logic       sda_m;
  logic       sda_bus;
  logic       sda_o;
  logic       rx_valid_o;
  logic [7:0] rx_data_o;
  logic [3:0] rx_addr_o;
  logic       busy_o;

  assign sda_bus = sda_m & sda_o;

  always #5 clk = ~clk;

  i2c_slave_responder dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .scl_i      (scl),
    .sda_i      (sda_bus),
    .sda_o      (sda_o),
    .rx_valid_o (rx_valid_o),
    .rx_data_o  (rx_data_o),
    .rx_addr_o  (rx_addr_o),
    .busy_o     (busy_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Strobe monitor
  logic [7:0] rx_dq[$];
  logic [3:0] rx_aq[$];
  int         sda_low_cnt = 0;

  always @(negedge clk) begin
    if (rx_valid_o) begin
      rx_dq.push_back(rx_data_o);
      rx_aq.push_back(rx_addr_o);
    end
    if (!sda_o) sda_low_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(5);
    sda_m = 1'b0; wait_clk(10);
    scl = 1'b0;
  endtask

  task automatic i2c_rstart();
    wait_clk(5); sda_m = 1'b1;
    wait_clk(5); scl = 1'b1;
    wait_clk(5); sda_m = 1'b0;
    wait_clk(5); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(5); sda_m = 1'b0;
    wait_clk(5); scl = 1'b1;
    wait_clk(5); sda_m = 1'b1;
    wait_clk(10);
  endtask

  task automatic put_bit(input logic b);
    wait_clk(5); sda_m = b;
    wait_clk(5); scl = 1'b1;
    wait_clk(10); scl = 1'b0;
  endtask

  task automatic get_bit(output logic b);
    wait_clk(5); sda_m = 1'b1;
    wait_clk(5); scl = 1'b1;
    wait_clk(5); b = sda_bus;
    wait_clk(5); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask

  // Reads a byte, then drives the master ACK/NAK bit and reports whether
  // the responder had released sda during that bit.
  task automatic recv_byte(input logic nak, output logic [7:0] d, output logic rel);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    wait_clk(5); sda_m = nak;
    wait_clk(5); scl = 1'b1;
    wait_clk(5); rel = sda_o;
    wait_clk(5); scl = 1'b0;
  endtask

  initial begin
    logic       ack, rel;
    logic [7:0] d;
    int         c0, lowc0;

    rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1;
    wait_clk(4);
    check_eq("rst_sda", sda_o, 1'b1);
    check_eq("rst_valid", rx_valid_o, 1'b0);
    check_eq("rst_data", rx_data_o, 8'h00);
    check_eq("rst_addr", rx_addr_o, 4'h0);
    check_eq("rst_busy", busy_o, 1'b0);
    rst_n = 1'b1;
    wait_clk(4);

    // Write 0x78 to register 5
    i2c_start();
    send_byte(8'h44, ack); check_eq("wr_addr_ack", ack, 1'b0);
    check_eq("wr_busy", busy_o, 1'b1);
    send_byte(8'h05, ack); check_eq("wr_ptr_ack", ack, 1'b0);
    c0 = rx_dq.size();
    send_byte(8'h78, ack); check_eq("wr_data_ack", ack, 1'b0);
    i2c_stop();
    check_eq("wr_pulses", rx_dq.size() - c0, 1);
    check_eq("wr_rx_data", rx_data_o, 8'h78);
    check_eq("wr_rx_addr", rx_addr_o, 4'h5);
    check_eq("wr_busy_stop", busy_o, 1'b0);

    // Read back register 5 through a repeated START
    i2c_start();
    send_byte(8'h44, ack); check_eq("rd_addr_ack", ack, 1'b0);
    send_byte(8'h05, ack); check_eq("rd_ptr_ack", ack, 1'b0);
    c0 = rx_dq.size();
    i2c_rstart();
    send_byte(8'h45, ack); check_eq("rd_raddr_ack", ack, 1'b0);
    recv_byte(1'b1, d, rel);
    check_eq("rd_data", d, 8'h78);
    check_eq("rd_mack_rel", rel, 1'b1);
    i2c_stop();
    check_eq("rd_no_pulse", rx_dq.size() - c0, 0);

    // Foreign address: no ACK, no drive, no store
    lowc0 = sda_low_cnt;
    c0 = rx_dq.size();
    i2c_start();
    send_byte(8'h46, ack); check_eq("mm_addr_nak", ack, 1'b1);
    send_byte(8'hAA, ack); check_eq("mm_data_nak", ack, 1'b1);
    i2c_stop();
    check_eq("mm_sda_low", sda_low_cnt - lowc0, 0);
    check_eq("mm_no_pulse", rx_dq.size() - c0, 0);
    check_eq("mm_busy", busy_o, 1'b0);
    i2c_start();
    send_byte(8'h44, ack);
    send_byte(8'h05, ack);
    i2c_rstart();
    send_byte(8'h45, ack);
    recv_byte(1'b1, d, rel);
    check_eq("mm_mem_kept", d, 8'h78);
    i2c_stop();

    // Pointer wrap 0xF -> 0x0
    i2c_start();
    send_byte(8'h44, ack);
    send_byte(8'h0F, ack);
    c0 = rx_dq.size();
    send_byte(8'h11, ack); check_eq("wrap_ack1", ack, 1'b0);
    send_byte(8'h22, ack); check_eq("wrap_ack2", ack, 1'b0);
    i2c_stop();
    check_eq("wrap_pulses", rx_dq.size() - c0, 2);
    if (rx_dq.size() - c0 == 2) begin
      check_eq("wrap_addr0", rx_aq[c0], 4'hF);
      check_eq("wrap_addr1", rx_aq[c0+1], 4'h0);
      check_eq("wrap_data0", rx_dq[c0], 8'h11);
      check_eq("wrap_data1", rx_dq[c0+1], 8'h22);
    end

    // Burst read across the wrap
    i2c_start();
    send_byte(8'h44, ack);
    send_byte(8'h0F, ack);
    i2c_rstart();
    send_byte(8'h45, ack); check_eq("br_addr_ack", ack, 1'b0);
    recv_byte(1'b0, d, rel);
    check_eq("br_data0", d, 8'h11);
    check_eq("br_rel0", rel, 1'b1);
    recv_byte(1'b1, d, rel);
    check_eq("br_data1", d, 8'h22);
    i2c_stop();

    // Reset while the responder drives bit 7 (=0) of mem[5]
    i2c_start();
    send_byte(8'h44, ack);
    send_byte(8'h05, ack);
    i2c_rstart();
    send_byte(8'h45, ack);
    wait_clk(5);
    check_eq("rr_tx_drive", sda_o, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rr_sda_rel", sda_o, 1'b1);
    check_eq("rr_busy", busy_o, 1'b0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(3);
    i2c_stop();
    i2c_start();
    send_byte(8'h44, ack); check_eq("rr_addr_ack", ack, 1'b0);
    send_byte(8'h05, ack);
    i2c_rstart();
    send_byte(8'h45, ack);
    recv_byte(1'b1, d, rel);
    check_eq("rr_mem_clr", d, 8'h00);
    i2c_stop();
    check_eq("rr_busy_end", busy_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
